// File: rtl/usb_fs_out_xfer_ctrl_pkg.sv
// USB PID encodings, PID-class helpers and the state/decision types shared by the
// full-speed OUT transfer controller.
package usb_fs_out_xfer_ctrl_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // The two PID LSBs encode the packet class
  localparam logic [3:0] PID_CLASS_MASK  = 4'b0011;
  localparam logic [3:0] PID_CLASS_TOKEN = 4'b0001;
  localparam logic [3:0] PID_CLASS_DATA  = 4'b0011;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, RX_DATA, HS_PEND} state_t;

  typedef enum logic [2:0] {
    DEC_NONE, DEC_DROP, DEC_STALL, DEC_NAK, DEC_DUP, DEC_COMMIT
  } decision_t;

  // OUT and SETUP are the token-class PIDs that are neither IN nor SOF
  function automatic logic pid_is_out_token(input logic [3:0] pid);
    return ((pid & PID_CLASS_MASK) == PID_CLASS_TOKEN) && (pid != PID_IN) && (pid != PID_SOF);
  endfunction

  // DATA0/DATA1 are the data-class PIDs with bit 2 clear (excludes DATA2/MDATA)
  function automatic logic pid_is_data01(input logic [3:0] pid);
    return ((pid & PID_CLASS_MASK) == PID_CLASS_DATA) && !pid[2];
  endfunction

endpackage

// File: rtl/usb_fs_out_xfer_ctrl_crc_strip.sv
// Two-byte delay line that withholds the trailing CRC16 from the payload stream,
// plus a saturating byte counter and babble detection.
module usb_fs_out_xfer_ctrl_crc_strip #(
  parameter int MAX_PKT = 64,
  parameter int CW      = $clog2(MAX_PKT + 4)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          put,
  input  logic [7:0]    data,
  output logic          fwd_put,
  output logic [7:0]    fwd_data,
  output logic [CW-1:0] count,
  output logic          babble
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT + 3);

  logic [7:0]    d0;
  logic [7:0]    d1;
  logic [CW-1:0] cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (put) begin
      d1 <= d0;
      d0 <= data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      fwd_put  <= 1'b0;
      fwd_data <= '0;
    end else begin
      // Once two bytes are held, each new put pushes the oldest one out
      fwd_put <= put && (cnt >= CW'(2));
      if (put && (cnt >= CW'(2))) fwd_data <= d1;
      if (clear)    cnt <= '0;
      else if (put) cnt <= sat_inc(cnt);
    end
  end

  // Count already includes a byte arriving this cycle, so an end-of-packet
  // decision taken in the same cycle sees it.
  assign count  = put ? sat_inc(cnt) : cnt;
  assign babble = count > CW'(MAX_PKT + 2);

endmodule

// File: rtl/usb_fs_out_xfer_ctrl.sv
// Full-speed OUT/SETUP transaction sequencer: token match, CRC-stripped payload
// routing to OUT endpoints, per-endpoint data toggle and ACK/NAK/STALL selection.
module usb_fs_out_xfer_ctrl
  import usb_fs_out_xfer_ctrl_pkg::*;
#(
  parameter int NUM_OUT_EP = 2,
  parameter int MAX_PKT    = 64,
  parameter int TOKEN_TO   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            dev_addr,
  input  logic                  rx_pkt_start,
  input  logic                  rx_pkt_end,
  input  logic [3:0]            rx_pid,
  input  logic [6:0]            rx_addr,
  input  logic [3:0]            rx_endp,
  input  logic                  rx_valid_packet,
  input  logic                  rx_data_put,
  input  logic [7:0]            rx_data,
  input  logic [NUM_OUT_EP-1:0] ep_ready,
  input  logic [NUM_OUT_EP-1:0] ep_stall,
  output logic [NUM_OUT_EP-1:0] ep_data_put,
  output logic [7:0]            ep_data,
  output logic [NUM_OUT_EP-1:0] ep_commit,
  output logic [NUM_OUT_EP-1:0] ep_rollback,
  output logic [NUM_OUT_EP-1:0] ep_setup,
  output logic                  tx_hs_req,
  output logic [3:0]            tx_hs_pid,
  input  logic                  tx_hs_ack
);

  localparam int EPW = (NUM_OUT_EP > 1) ? $clog2(NUM_OUT_EP) : 1;
  localparam int CW  = $clog2(MAX_PKT + 4);
  localparam int TW  = $clog2(TOKEN_TO + 1);

  state_t                state, state_nx;
  decision_t             dec;
  logic [EPW-1:0]        ep_q;
  logic [EPW-1:0]        ep_sel;
  logic                  is_setup_q, ready_q, stall_q;
  logic [NUM_OUT_EP-1:0] toggle;
  logic [TW-1:0]         to_cnt;
  logic                  commit_q, rollback_q, setup_q, hs_req_q;
  logic [3:0]            hs_pid_q;
  logic                  token_hit;
  logic                  strip_clear, strip_put, fwd_put, babble;
  logic [7:0]            fwd_data;
  logic [CW-1:0]         byte_cnt;

  assign ep_sel    = rx_endp[EPW-1:0];
  assign token_hit = rx_pkt_end && rx_valid_packet && pid_is_out_token(rx_pid) &&
                     (rx_addr == dev_addr) && ({1'b0, rx_endp} < 5'(NUM_OUT_EP));

  assign strip_clear = (state == WAIT_DATA) && rx_pkt_start;
  assign strip_put   = (state == RX_DATA) && rx_data_put;

  usb_fs_out_xfer_ctrl_crc_strip #(
    .MAX_PKT (MAX_PKT),
    .CW      (CW)
  ) u_strip (
    .clk      (clk),
    .reset    (reset),
    .clear    (strip_clear),
    .put      (strip_put),
    .data     (rx_data),
    .fwd_put  (fwd_put),
    .fwd_data (fwd_data),
    .count    (byte_cnt),
    .babble   (babble)
  );

  always_comb begin
    state_nx = state;
    dec      = DEC_NONE;
    case (state)
      IDLE:      if (token_hit) state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (rx_pkt_start)                        state_nx = RX_DATA;
        else if (to_cnt == TW'(TOKEN_TO - 1))    state_nx = IDLE;
      end
      RX_DATA: begin
        if (rx_pkt_end) begin
          if (!rx_valid_packet || !pid_is_data01(rx_pid) || babble || (byte_cnt < CW'(2)))
            dec = DEC_DROP;
          else if (stall_q)                                  dec = DEC_STALL;
          else if (!ready_q)                                 dec = DEC_NAK;
          else if ((rx_pid == PID_DATA1) != toggle[ep_q])    dec = DEC_DUP;
          else                                               dec = DEC_COMMIT;
          state_nx = (dec == DEC_DROP) ? IDLE : HS_PEND;
        end
      end
      HS_PEND:   if (rx_pkt_start || tx_hs_ack) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ep_q       <= '0;
      is_setup_q <= 1'b0;
      ready_q    <= 1'b0;
      stall_q    <= 1'b0;
      toggle     <= '0;
      to_cnt     <= '0;
      commit_q   <= 1'b0;
      rollback_q <= 1'b0;
      setup_q    <= 1'b0;
      hs_req_q   <= 1'b0;
      hs_pid_q   <= '0;
    end else begin
      state      <= state_nx;
      commit_q   <= (dec == DEC_COMMIT);
      rollback_q <= dec inside {DEC_DROP, DEC_STALL, DEC_NAK, DEC_DUP};
      setup_q    <= (dec == DEC_COMMIT) && is_setup_q;

      // SETUP always restarts the control pipe at DATA0 and clears a halt
      if ((state == IDLE) && token_hit) begin
        ep_q       <= ep_sel;
        is_setup_q <= (rx_pid == PID_SETUP);
        ready_q    <= ep_ready[ep_sel];
        stall_q    <= ep_stall[ep_sel] && (rx_pid != PID_SETUP);
        to_cnt     <= '0;
        if (rx_pid == PID_SETUP) toggle[ep_sel] <= 1'b0;
      end else if (state == WAIT_DATA) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (dec == DEC_COMMIT) toggle[ep_q] <= ~toggle[ep_q];

      case (dec)
        DEC_STALL:           begin hs_req_q <= 1'b1; hs_pid_q <= PID_STALL; end
        DEC_NAK:             begin hs_req_q <= 1'b1; hs_pid_q <= PID_NAK;   end
        DEC_DUP, DEC_COMMIT: begin hs_req_q <= 1'b1; hs_pid_q <= PID_ACK;   end
        default: begin
          if ((state == HS_PEND) && (rx_pkt_start || tx_hs_ack)) begin
            hs_req_q <= 1'b0;
            hs_pid_q <= '0;
          end
        end
      endcase
    end
  end

  // A byte forwarded alongside a commit/rollback pulse is suppressed so the
  // endpoint never sees a strobe and a verdict in the same cycle.
  always_comb begin
    ep_data_put = '0;
    ep_commit   = '0;
    ep_rollback = '0;
    ep_setup    = '0;
    for (int i = 0; i < NUM_OUT_EP; i++) begin
      if (ep_q == EPW'(i)) begin
        ep_data_put[i] = fwd_put && ready_q && !stall_q && !commit_q && !rollback_q;
        ep_commit[i]   = commit_q;
        ep_rollback[i] = rollback_q;
        ep_setup[i]    = setup_q;
      end
    end
  end

  assign ep_data   = fwd_data;
  assign tx_hs_req = hs_req_q;
  assign tx_hs_pid = hs_pid_q;

endmodule

// File: tb/tb_usb_fs_out_xfer_ctrl.sv
// Directed bench for usb_fs_out_xfer_ctrl: OUT/SETUP transactions with
// hand-computed per-endpoint strobe, verdict and handshake counts.
module tb_usb_fs_out_xfer_ctrl;
  import usb_fs_out_xfer_ctrl_pkg::*;

  localparam int N    = 2;
  localparam int MAXP = 64;
  localparam int TTO  = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   dev_addr;
  logic         rx_pkt_start, rx_pkt_end, rx_valid_packet, rx_data_put;
  logic [3:0]   rx_pid, rx_endp;
  logic [6:0]   rx_addr;
  logic [7:0]   rx_data;
  logic [N-1:0] ep_ready, ep_stall;
  logic [N-1:0] ep_data_put, ep_commit, ep_rollback, ep_setup;
  logic [7:0]   ep_data;
  logic         tx_hs_req, tx_hs_ack;
  logic [3:0]   tx_hs_pid;

  always #5 clk = ~clk;

  usb_fs_out_xfer_ctrl #(.NUM_OUT_EP(N), .MAX_PKT(MAXP), .TOKEN_TO(TTO)) dut (
    .clk(clk), .reset(reset), .dev_addr(dev_addr),
    .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pid(rx_pid),
    .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_valid_packet(rx_valid_packet),
    .rx_data_put(rx_data_put), .rx_data(rx_data),
    .ep_ready(ep_ready), .ep_stall(ep_stall),
    .ep_data_put(ep_data_put), .ep_data(ep_data), .ep_commit(ep_commit),
    .ep_rollback(ep_rollback), .ep_setup(ep_setup),
    .tx_hs_req(tx_hs_req), .tx_hs_pid(tx_hs_pid), .tx_hs_ack(tx_hs_ack)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         put_cnt[N], com_cnt[N], rb_cnt[N], set_cnt[N];
  int         s_put[N], s_com[N], s_rb[N], s_set[N];
  int         excl_err = 0;
  logic [7:0] bytes_q[$];
  logic [3:0] hs_got;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ep_data_put[i]) begin put_cnt[i]++; bytes_q.push_back(ep_data); end
      if (ep_commit[i])   com_cnt[i]++;
      if (ep_rollback[i]) rb_cnt[i]++;
      if (ep_setup[i])    set_cnt[i]++;
    end
    if (int'(|ep_data_put) + int'(|ep_commit) + int'(|ep_rollback) > 1) excl_err++;
  end

  function automatic logic [7:0] pay(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) begin
      s_put[i] = put_cnt[i]; s_com[i] = com_cnt[i];
      s_rb[i]  = rb_cnt[i];  s_set[i] = set_cnt[i];
    end
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    rx_pkt_start = 1'b1; tick(); rx_pkt_start = 1'b0; tick();
    rx_pid = pid; rx_addr = addr; rx_endp = endp;
    rx_valid_packet = 1'b1; rx_pkt_end = 1'b1; tick();
    rx_pkt_end = 1'b0; rx_valid_packet = 1'b0; tick();
  endtask

  task automatic send_data(input logic [3:0] pid, input int n, input logic ok);
    rx_pkt_start = 1'b1; tick(); rx_pkt_start = 1'b0;
    for (int i = 0; i < n + 2; i++) begin
      rx_data = (i < n) ? pay(i) : 8'hEE;
      rx_data_put = 1'b1; tick(); rx_data_put = 1'b0; tick();
    end
    rx_pid = pid; rx_valid_packet = ok; rx_pkt_end = 1'b1; tick();
    rx_pkt_end = 1'b0; rx_valid_packet = 1'b0;
  endtask

  task automatic wait_hs();
    hs_got = 4'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_hs_req) begin
        hs_got = tx_hs_pid;
        @(posedge clk); #1;
        tx_hs_ack = 1'b1; tick(); tx_hs_ack = 1'b0;
        break;
      end
    end
    tick();
  endtask

  task automatic xfer(input logic [3:0] tpid, input logic [6:0] addr, input logic [3:0] endp,
                      input logic [3:0] dpid, input int n, input logic ok, input int gap);
    snap();
    send_token(tpid, addr, endp);
    repeat (gap) tick();
    send_data(dpid, n, ok);
    wait_hs();
  endtask

  task automatic chk_xfer(input string tag, input int ep, input int puts, input int com,
                          input int rb, input int set, input logic [3:0] hs);
    int o;
    o = 1 - ep;
    check({tag, ".puts"},     put_cnt[ep] - s_put[ep], puts);
    check({tag, ".commit"},   com_cnt[ep] - s_com[ep], com);
    check({tag, ".rollback"}, rb_cnt[ep]  - s_rb[ep],  rb);
    check({tag, ".setup"},    set_cnt[ep] - s_set[ep], set);
    check({tag, ".other_ep"}, (put_cnt[o] - s_put[o]) + (com_cnt[o] - s_com[o]) +
                              (rb_cnt[o] - s_rb[o]) + (set_cnt[o] - s_set[o]), 0);
    check({tag, ".hs_pid"},   hs_got, hs);
    check({tag, ".hs_idle"},  tx_hs_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b0; dev_addr = 7'd5;
    rx_pkt_start = 0; rx_pkt_end = 0; rx_valid_packet = 0; rx_data_put = 0;
    rx_pid = 0; rx_addr = 0; rx_endp = 0; rx_data = 0;
    ep_ready = 2'b11; ep_stall = 2'b00; tx_hs_ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {ep_data_put, ep_commit, ep_rollback, ep_setup, tx_hs_req, tx_hs_pid, ep_data}, 0);
    check("rst_toggle", dut.toggle, 0);
    reset = 1'b1; tick(); tick();

    base = bytes_q.size();
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("out1_d0", 1, 4, 1, 0, 0, PID_ACK);
    check("out1_nbytes", bytes_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (bytes_q.size() > base + i) check($sformatf("out1_byte%0d", i), bytes_q[base + i], pay(i));

    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("out1_dup", 1, 4, 0, 1, 0, PID_ACK);
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA1, 4, 1'b1, 0);
    chk_xfer("out1_d1", 1, 4, 1, 0, 0, PID_ACK);

    xfer(PID_OUT, 7'd5, 4'd0, PID_DATA0, 2, 1'b1, 0);
    chk_xfer("out0_d0", 0, 2, 1, 0, 0, PID_ACK);
    ep_stall = 2'b01;
    xfer(PID_SETUP, 7'd5, 4'd0, PID_DATA0, 8, 1'b1, 0);
    chk_xfer("setup0", 0, 8, 1, 0, 1, PID_ACK);
    ep_stall = 2'b00;
    check("setup0_toggle", dut.toggle, 2'b01);

    ep_ready = 2'b10;
    xfer(PID_OUT, 7'd5, 4'd0, PID_DATA1, 4, 1'b1, 0);
    chk_xfer("out0_nak", 0, 0, 0, 1, 0, PID_NAK);
    ep_ready = 2'b11;

    ep_stall = 2'b10;
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("out1_stall", 1, 0, 0, 1, 0, PID_STALL);
    ep_stall = 2'b00;

    xfer(PID_OUT, 7'd6, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("wrong_addr", 1, 0, 0, 0, 0, 4'h0);
    xfer(PID_OUT, 7'd5, 4'd3, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("wrong_endp", 1, 0, 0, 0, 0, 4'h0);
    xfer(PID_IN, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("in_token", 1, 0, 0, 0, 0, 4'h0);

    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b0, 0);
    chk_xfer("bad_crc", 1, 4, 0, 1, 0, 4'h0);
    xfer(PID_OUT, 7'd5, 4'd1, PID_SOF, 4, 1'b1, 0);
    chk_xfer("bad_pid", 1, 4, 0, 1, 0, 4'h0);
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, MAXP + 3, 1'b1, 0);
    chk_xfer("babble", 1, MAXP + 3, 0, 1, 0, 4'h0);
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, TTO + 36);
    chk_xfer("timeout", 1, 0, 0, 0, 0, 4'h0);

    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("recover", 1, 4, 1, 0, 0, PID_ACK);
    check("pre_rst_toggle", dut.toggle, 2'b11);

    snap();
    send_token(PID_OUT, 7'd5, 4'd1);
    rx_pkt_start = 1'b1; tick(); rx_pkt_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data = pay(i); rx_data_put = 1'b1; tick(); rx_data_put = 1'b0;
      if (i < 2) tick();
    end
    check("mid_fwd", ep_data_put, 2'b10);
    reset = 1'b0; #1;
    check("mid_rst_outputs", {ep_data_put, ep_commit, ep_rollback, ep_setup, tx_hs_req, tx_hs_pid, ep_data}, 0);
    check("mid_rst_toggle", dut.toggle, 0);
    tick(); tick();
    reset = 1'b1; tick(); tick();
    check("mid_rst_verdicts", (com_cnt[1] - s_com[1]) + (rb_cnt[1] - s_rb[1]) +
                              (com_cnt[0] - s_com[0]) + (rb_cnt[0] - s_rb[0]), 0);
    xfer(PID_OUT, 7'd5, 4'd1, PID_DATA0, 4, 1'b1, 0);
    chk_xfer("post_rst", 1, 4, 1, 0, 0, PID_ACK);

    check("exclusive", excl_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
